// File: rtl/preg_alloc_ctrl_pkg.sv
// Shared sizing constants and state types for the
// physical register allocation controller.
package params;
   localparam int NUM_PREG = 64;
   localparam int PREG_W   = $clog2(NUM_PREG);
   localparam int NUM_AREG = 32;
endpackage

package rv32i_types;
   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_REBUILD = 2'd1,
      ST_RUN     = 2'd2
   } alloc_state_e;
endpackage

// File: rtl/preg_alloc_ctrl.sv
// Physical register allocator control: drives the free list FIFO,
// tracks committed mappings and rebuilds the free list after flush.
module preg_alloc_ctrl
   import rv32i_types::*;
#(
   parameter int NUM_PREG = params::NUM_PREG,
   parameter int PREG_W   = params::PREG_W,
   parameter int NUM_AREG = params::NUM_AREG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ren_valid,
   input  logic              ren_rd_used,
   output logic              ren_ready,
   output logic [PREG_W-1:0] ren_pd,
   input  logic              cmt_valid,
   input  logic              cmt_free_en,
   input  logic [PREG_W-1:0] cmt_pd_new,
   input  logic [PREG_W-1:0] cmt_pd_old,
   output logic              cmt_ready,
   input  logic [PREG_W-1:0] fl_rdata,
   input  logic              fl_empty,
   input  logic              fl_full,
   output logic              fl_dequeue,
   output logic              fl_enqueue,
   output logic [PREG_W-1:0] fl_wdata,
   output logic              fl_clear,
   output logic [PREG_W:0]   free_count,
   output logic              err_overflow
);

   localparam logic [NUM_PREG-1:0] BM_RST =
      {{(NUM_PREG-NUM_AREG){1'b0}}, {NUM_AREG{1'b1}}};
   localparam logic [PREG_W-1:0] LAST_IDX =
      PREG_W'(NUM_PREG-1);

   alloc_state_e          r_state;
   logic [NUM_PREG-1:0]   r_bitmap;
   logic [PREG_W-1:0]     r_scan;
   logic [PREG_W:0]       r_free_count;
   logic                  r_err;

   alloc_state_e          w_state_nxt;
   logic [NUM_PREG-1:0]   w_bm_nxt;
   logic [PREG_W:0]       w_cnt_nxt;
   logic                  w_ren_ready;
   logic                  w_cmt_ready;
   logic                  w_deq;
   logic                  w_enq;
   logic [PREG_W-1:0]     w_wdata;
   logic                  w_fl_clear;
   logic                  w_cmt_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_CLEAR;
         r_bitmap     <= BM_RST;
         r_scan       <= '0;
         r_free_count <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_bitmap <= w_bm_nxt;
         if (r_state == ST_CLEAR) begin
            r_scan       <= '0;
            r_free_count <= '0;
         end else begin
            if (r_state == ST_REBUILD)
               r_scan <= r_scan + 1'b1;
            r_free_count <= w_cnt_nxt;
         end
         if (w_enq && fl_full)
            r_err <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fl_clear  = 1'b0;
      w_enq       = 1'b0;
      w_wdata     = '0;
      w_ren_ready = 1'b0;
      w_cmt_ready = 1'b0;
      w_deq       = 1'b0;
      unique case (r_state)
         ST_CLEAR: begin
            w_fl_clear  = 1'b1;
            w_state_nxt = ST_REBUILD;
         end
         ST_REBUILD: begin
            w_enq   = !r_bitmap[r_scan] && !flush;
            w_wdata = r_scan;
            if (flush)
               w_state_nxt = ST_CLEAR;
            else if (r_scan == LAST_IDX)
               w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_ren_ready = !ren_rd_used || !fl_empty;
            w_cmt_ready = 1'b1;
            w_deq = ren_valid && w_ren_ready &&
                    ren_rd_used && !flush;
            // a flush rebuilds from the bitmap, so the freed reg
            // must not also be pushed here
            w_enq = cmt_valid && cmt_free_en &&
                    (cmt_pd_old != '0) && !flush;
            w_wdata = cmt_pd_old;
            if (flush)
               w_state_nxt = ST_CLEAR;
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
      if (!w_enq)
         w_wdata = '0;
   end

   assign w_cmt_fire = cmt_valid && w_cmt_ready;

   always_comb begin
      w_bm_nxt = r_bitmap;
      if (w_cmt_fire && cmt_free_en) begin
         w_bm_nxt[cmt_pd_new] = 1'b1;
         w_bm_nxt[cmt_pd_old] = 1'b0;
      end
      w_bm_nxt[0] = 1'b1;
   end

   always_comb begin
      w_cnt_nxt = r_free_count;
      if (w_enq && !w_deq)
         w_cnt_nxt = r_free_count + 1'b1;
      else if (!w_enq && w_deq)
         w_cnt_nxt = r_free_count - 1'b1;
   end

   assign ren_ready    = !rst && w_ren_ready;
   assign cmt_ready    = !rst && w_cmt_ready;
   assign fl_dequeue   = !rst && w_deq;
   assign fl_enqueue   = !rst && w_enq;
   assign fl_wdata     = rst ? '0 : w_wdata;
   assign fl_clear     = !rst && w_fl_clear;
   assign free_count   = rst ? '0 : r_free_count;
   assign err_overflow = !rst && r_err;
   assign ren_pd       = (!rst && ren_rd_used) ? fl_rdata : '0;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed bench for preg_alloc_ctrl with a behavioural free list.
module tb_preg_alloc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       ren_valid;
   logic       ren_rd_used;
   logic       ren_ready;
   logic [5:0] ren_pd;
   logic       cmt_valid;
   logic       cmt_free_en;
   logic [5:0] cmt_pd_new;
   logic [5:0] cmt_pd_old;
   logic       cmt_ready;
   logic [5:0] fl_rdata;
   logic       fl_empty;
   logic       fl_full;
   logic       fl_dequeue;
   logic       fl_enqueue;
   logic [5:0] fl_wdata;
   logic       fl_clear;
   logic [6:0] free_count;
   logic       err_overflow;
   logic       force_full;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   preg_alloc_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ren_valid(ren_valid), .ren_rd_used(ren_rd_used),
      .ren_ready(ren_ready), .ren_pd(ren_pd),
      .cmt_valid(cmt_valid), .cmt_free_en(cmt_free_en),
      .cmt_pd_new(cmt_pd_new), .cmt_pd_old(cmt_pd_old),
      .cmt_ready(cmt_ready),
      .fl_rdata(fl_rdata), .fl_empty(fl_empty),
      .fl_full(fl_full),
      .fl_dequeue(fl_dequeue), .fl_enqueue(fl_enqueue),
      .fl_wdata(fl_wdata), .fl_clear(fl_clear),
      .free_count(free_count), .err_overflow(err_overflow)
   );

   logic [5:0] m_mem [0:63];
   logic [6:0] m_head = 7'd0;
   logic [6:0] m_tail = 7'd0;
   logic [6:0] m_cnt;

   assign m_cnt    = m_tail - m_head;
   assign fl_empty = (m_cnt == 7'd0);
   assign fl_full  = force_full || (m_cnt >= 7'd32);
   assign fl_rdata = fl_empty ? 6'd0 : m_mem[m_head[5:0]];

   always @(posedge clk) begin
      if (fl_clear) begin
         m_head <= 7'd0;
         m_tail <= 7'd0;
      end else begin
         if (fl_dequeue && m_cnt != 7'd0)
            m_head <= m_head + 7'd1;
         if (fl_enqueue && m_cnt < 7'd64) begin
            m_mem[m_tail[5:0]] <= fl_wdata;
            m_tail <= m_tail + 7'd1;
         end
      end
   end

   typedef struct {
      logic       vld, rdu, cv, cfe;
      logic [5:0] cn, co;
      logic       rdy;
      logic [5:0] pd;
      logic       deq, enq;
      logic [5:0] wd;
      logic [6:0] cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic vld, input logic rdu,
      input logic cv, input logic cfe,
      input logic [5:0] cn, input logic [5:0] co,
      input logic rdy, input logic [5:0] pd,
      input logic deq, input logic enq,
      input logic [5:0] wd, input logic [6:0] cnt);
      vec_t v;
      v.vld = vld; v.rdu = rdu; v.cv = cv; v.cfe = cfe;
      v.cn = cn; v.co = co; v.rdy = rdy; v.pd = pd;
      v.deq = deq; v.enq = enq; v.wd = wd; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0;
      ren_valid = 1'b0;
      ren_rd_used = 1'b1;
      cmt_valid = 1'b0;
      cmt_free_en = 1'b0;
      cmt_pd_new = 6'd0;
      cmt_pd_old = 6'd0;
   endtask

   task automatic wait_run(output int cyc);
      cyc = 0;
      while (cyc < 200 && ren_ready !== 1'b1) begin
         cyc++;
         tick();
      end
   endtask

   task automatic chk_fifo(input logic [63:0] bm);
      int n;
      logic [6:0] idx;
      n = 0;
      for (int i = 1; i < 64; i++) begin
         if (!bm[i]) begin
            idx = m_head + 7'(n);
            chk("fifo_entry", 32'(m_mem[idx[5:0]]), 32'(i));
            n++;
         end
      end
      chk("fifo_count", 32'(m_cnt), 32'(n));
      chk("free_count", 32'(free_count), 32'(n));
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_ren_ready"}, 32'(ren_ready), 0);
      chk({tag, "_ren_pd"}, 32'(ren_pd), 0);
      chk({tag, "_cmt_ready"}, 32'(cmt_ready), 0);
      chk({tag, "_fl_deq"}, 32'(fl_dequeue), 0);
      chk({tag, "_fl_enq"}, 32'(fl_enqueue), 0);
      chk({tag, "_fl_wdata"}, 32'(fl_wdata), 0);
      chk({tag, "_fl_clear"}, 32'(fl_clear), 0);
      chk({tag, "_free_count"}, 32'(free_count), 0);
      chk({tag, "_err"}, 32'(err_overflow), 0);
   endtask

   vec_t tv [17];
   logic [63:0] bm;
   logic [5:0] exp_list [0:63];
   int n_exp;
   int cyc;
   int drained;

   initial begin
      force_full = 1'b0;
      idle();
      rst = 1'b1;
      cmt_valid = 1'b1;
      cmt_free_en = 1'b1;
      cmt_pd_old = 6'd4;
      ren_valid = 1'b1;
      repeat (3) tick();
      chk_zero_outs("rst");
      idle();

      rst = 1'b0;
      #1;
      chk("init_fl_clear", 32'(fl_clear), 1);
      wait_run(cyc);
      chk("init_stall", 32'(cyc), 65);
      bm = 64'h0000_0000_FFFF_FFFF;
      chk_fifo(bm);

      for (int i = 0; i < 10; i++)
         tv[i] = mk(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0,
                    1'b1, 6'(32 + i), 1'b1, 1'b0, 6'd0,
                    7'(32 - i));
      tv[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0,
                  1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 7'd22);
      tv[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0,
                  1'b1, 6'd42, 1'b0, 1'b0, 6'd0, 7'd22);
      tv[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd32, 6'd7,
                  1'b1, 6'd0, 1'b0, 1'b1, 6'd7, 7'd22);
      tv[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd33, 6'd8,
                  1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 7'd23);
      tv[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd34, 6'd0,
                  1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 7'd23);
      tv[15] = mk(1'b1, 1'b1, 1'b1, 1'b1, 6'd35, 6'd9,
                  1'b1, 6'd42, 1'b1, 1'b1, 6'd9, 7'd23);
      tv[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0,
                  1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 7'd23);

      for (int i = 0; i < 17; i++) begin
         ren_valid = tv[i].vld;
         ren_rd_used = tv[i].rdu;
         cmt_valid = tv[i].cv;
         cmt_free_en = tv[i].cfe;
         cmt_pd_new = tv[i].cn;
         cmt_pd_old = tv[i].co;
         #1;
         chk($sformatf("v%0d_ren_ready", i),
             32'(ren_ready), 32'(tv[i].rdy));
         chk($sformatf("v%0d_ren_pd", i),
             32'(ren_pd), 32'(tv[i].pd));
         chk($sformatf("v%0d_deq", i),
             32'(fl_dequeue), 32'(tv[i].deq));
         chk($sformatf("v%0d_enq", i),
             32'(fl_enqueue), 32'(tv[i].enq));
         chk($sformatf("v%0d_wdata", i),
             32'(fl_wdata), 32'(tv[i].wd));
         chk($sformatf("v%0d_free_count", i),
             32'(free_count), 32'(tv[i].cnt));
         chk($sformatf("v%0d_cmt_ready", i),
             32'(cmt_ready), 1);
         if (tv[i].cv && tv[i].cfe) begin
            bm[tv[i].cn] = 1'b1;
            if (tv[i].co != 6'd0)
               bm[tv[i].co] = 1'b0;
         end
         tick();
      end
      idle();

      ren_valid = 1'b1;
      cmt_valid = 1'b1;
      cmt_free_en = 1'b1;
      cmt_pd_new = 6'd33;
      cmt_pd_old = 6'd3;
      flush = 1'b1;
      #1;
      chk("cf_enq_suppressed", 32'(fl_enqueue), 0);
      chk("cf_deq_suppressed", 32'(fl_dequeue), 0);
      bm[33] = 1'b1;
      bm[3] = 1'b0;
      tick();
      idle();
      #1;
      chk("cf_fl_clear", 32'(fl_clear), 1);
      chk("cf_ren_ready", 32'(ren_ready), 0);
      chk("cf_cmt_ready", 32'(cmt_ready), 0);
      wait_run(cyc);
      chk("cf_stall", 32'(cyc), 65);
      chk_fifo(bm);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("rb_fl_clear0", 32'(fl_clear), 1);
      repeat (21) tick();
      chk("rb_mid_count", 32'(free_count), 3);
      chk("rb_mid_ready", 32'(ren_ready), 0);
      flush = 1'b1;
      #1;
      chk("rb_flush_enq", 32'(fl_enqueue), 0);
      tick();
      flush = 1'b0;
      #1;
      chk("rb_fl_clear1", 32'(fl_clear), 1);
      wait_run(cyc);
      chk("rb_stall", 32'(cyc), 65);
      chk_fifo(bm);

      n_exp = 0;
      for (int i = 1; i < 64; i++)
         if (!bm[i]) begin
            exp_list[n_exp] = 6'(i);
            n_exp++;
         end
      drained = 0;
      ren_valid = 1'b1;
      ren_rd_used = 1'b1;
      for (int k = 0; k < 64; k++) begin
         #1;
         if (ren_ready !== 1'b1) break;
         chk("drain_pd", 32'(ren_pd), 32'(exp_list[drained]));
         drained++;
         tick();
      end
      chk("drain_num", 32'(drained), 32'(n_exp));
      chk("drain_ready", 32'(ren_ready), 0);
      chk("drain_deq", 32'(fl_dequeue), 0);
      ren_rd_used = 1'b0;
      #1;
      chk("drain_x0_ready", 32'(ren_ready), 1);
      ren_valid = 1'b0;
      cmt_valid = 1'b1;
      cmt_free_en = 1'b1;
      cmt_pd_new = 6'd40;
      cmt_pd_old = 6'd5;
      #1;
      chk("p5_enq", 32'(fl_enqueue), 1);
      chk("p5_wdata", 32'(fl_wdata), 5);
      chk("p5_count0", 32'(free_count), 0);
      tick();
      idle();
      #1;
      chk("p5_ready", 32'(ren_ready), 1);
      chk("p5_pd", 32'(ren_pd), 5);
      chk("p5_count1", 32'(free_count), 1);

      force_full = 1'b1;
      cmt_valid = 1'b1;
      cmt_free_en = 1'b1;
      cmt_pd_new = 6'd41;
      cmt_pd_old = 6'd10;
      #1;
      chk("ovf_enq", 32'(fl_enqueue), 1);
      chk("ovf_err_pre", 32'(err_overflow), 0);
      tick();
      idle();
      force_full = 1'b0;
      #1;
      chk("ovf_err_set", 32'(err_overflow), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      chk("ovf_err_sticky", 32'(err_overflow), 1);
      rst = 1'b1;
      cmt_valid = 1'b1;
      cmt_free_en = 1'b1;
      cmt_pd_old = 6'd12;
      ren_valid = 1'b1;
      #1;
      chk_zero_outs("rst2");
      tick();
      idle();
      rst = 1'b0;
      #1;
      chk("ovf_err_clr", 32'(err_overflow), 0);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mid_clear", 32'(fl_clear), 1);
      wait_run(cyc);
      chk("rst_mid_stall", 32'(cyc), 65);
      bm = 64'h0000_0000_FFFF_FFFF;
      chk_fifo(bm);
      chk("final_err", 32'(err_overflow), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
